// File: rtl/neuron_mac_unit.sv
// Serial neuron: four signed MACs over latched operands, then arithmetic scale and saturate.
// Optional build macro NEURON_RELU_EN clamps negative results to zero after saturation.
module neuron_mac_unit #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 18,
  parameter int unsigned SHIFT = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] x0,
  input  logic signed [DW-1:0] x1,
  input  logic signed [DW-1:0] x2,
  input  logic signed [DW-1:0] x3,
  input  logic signed [DW-1:0] w0,
  input  logic signed [DW-1:0] w1,
  input  logic signed [DW-1:0] w2,
  input  logic signed [DW-1:0] w3,
  input  logic signed [DW-1:0] bias,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] result
);

  localparam int unsigned PW = 2 * DW;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [3:0][DW-1:0]     x_q, x_d;
  logic [3:0][DW-1:0]     w_q, w_d;
  logic                   busy_d;
  logic                   done_d;
  logic signed [DW-1:0]   result_d;

  logic signed [PW-1:0]   prod_c;
  logic signed [AW-1:0]   scaled_c;
  logic signed [AW-1:0]   sat_c;

  // Datapath: current-lane product and scaled/saturated accumulator
  always_comb begin
    prod_c   = PW'($signed(x_q[idx_q])) * PW'($signed(w_q[idx_q]));
    scaled_c = acc_q >>> SHIFT;
    sat_c    = scaled_c;
    if (scaled_c > SAT_MAX) begin
      sat_c = SAT_MAX;
    end else if (scaled_c < SAT_MIN) begin
      sat_c = SAT_MIN;
    end
`ifdef NEURON_RELU_EN
    if (sat_c[AW-1]) begin
      sat_c = '0;
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    x_d      = x_q;
    w_d      = w_q;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = {x3, x2, x1, x0};
          w_d     = {w3, w2, w1, w0};
          acc_d   = AW'(bias);
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + AW'(prod_c);
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        result_d = DW'(sat_c);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      acc_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Bench for neuron_mac_unit: directed corner vectors plus randomized operands against a plain-arithmetic model.
module tb_neuron_mac_unit;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic signed [7:0] x0, x1, x2, x3;
  logic signed [7:0] w0, w1, w2, w3;
  logic signed [7:0] bias;
  logic              busy;
  logic              done;
  logic signed [7:0] result;

  int checks;
  int failures;

  neuron_mac_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x0     (x0),
    .x1     (x1),
    .x2     (x2),
    .x3     (x3),
    .w0     (w0),
    .w1     (w1),
    .w2     (w2),
    .w3     (w3),
    .bias   (bias),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Neuron value from arithmetic on plain integers
  function automatic int ref_model(input logic [3:0][7:0] xv, input logic [3:0][7:0] wv,
                                   input logic [7:0] b);
    int sum;
    sum = int'($signed(b));
    for (int i = 0; i < 4; i++) begin
      sum += int'($signed(xv[i])) * int'($signed(wv[i]));
    end
    sum = sum >>> 7;
    if (sum > 127) sum = 127;
    else if (sum < -128) sum = -128;
`ifdef NEURON_RELU_EN
    if (sum < 0) sum = 0;
`endif
    return sum;
  endfunction

  task automatic apply(input logic [3:0][7:0] xv, input logic [3:0][7:0] wv, input logic [7:0] b);
    x0 = xv[0]; x1 = xv[1]; x2 = xv[2]; x3 = xv[3];
    w0 = wv[0]; w1 = wv[1]; w2 = wv[2]; w3 = wv[3];
    bias = b;
  endtask

  task automatic scramble();
    x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom); x3 = 8'($urandom);
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
    bias = 8'($urandom);
  endtask

  // One full transaction; operands and start are disturbed while busy
  task automatic do_op(input string tag, input logic [3:0][7:0] xv, input logic [3:0][7:0] wv,
                       input logic [7:0] b, input int expv);
    @(negedge clk);
    apply(xv, wv, b);
    start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_e0"}, 32'(busy), 1);
    chk({tag, "_done_e0"}, 32'(done), 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      scramble();
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk({tag, "_busy_mac"}, 32'(busy), 1);
      chk({tag, "_done_mac"}, 32'(done), 0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_e5"}, 32'(done), 1);
    chk({tag, "_busy_e5"}, 32'(busy), 0);
    chk({tag, "_result"}, 32'($signed(result)), expv);
    @(posedge clk); #1;
    chk({tag, "_done_e6"}, 32'(done), 0);
    chk({tag, "_hold"}, 32'($signed(result)), expv);
  endtask

  initial begin
    logic [3:0][7:0] xv, wv;
    logic [7:0]      b;
    int              exp_neg, exp_min, done_seen, pick;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    apply('0, '0, 8'd0);
`ifdef NEURON_RELU_EN
    exp_neg = 0;
    exp_min = 0;
`else
    exp_neg = -127;
    exp_min = -128;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'($signed(result)), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("unit", {8'd0, 8'd0, 8'd0, 8'd2}, {8'd64, 8'd64, 8'd64, 8'd64}, 8'd0, 1);
    do_op("possat", {8'd64, 8'd64, 8'd64, 8'd64}, {8'd64, 8'd64, 8'd64, 8'd64}, 8'd0, 127);
    do_op("neg", {8'd0, 8'd0, 8'd0, 8'd127}, {8'd0, 8'd0, 8'd0, 8'h80}, 8'd0, exp_neg);
    do_op("negsat", {8'd127, 8'd127, 8'd127, 8'd127}, {8'h80, 8'h80, 8'h80, 8'h80}, 8'd0, exp_min);
    do_op("bias", {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 8'h80, -1 * (exp_min == 0 ? 0 : 1));

    // Reset two cycles into a computation must discard it
    @(negedge clk);
    apply({8'd64, 8'd64, 8'd64, 8'd64}, {8'd64, 8'd64, 8'd64, 8'd64}, 8'd0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'($signed(result)), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    chk("midrst_quiet", 32'(done_seen), 0);

    // start held high: accepted at E0 and E6, done after E5 and E11
    @(negedge clk);
    apply({8'd0, 8'd0, 8'd0, 8'd6}, {8'd0, 8'd0, 8'd0, 8'd64}, 8'd0);
    start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("held_done", 32'(done), (k == 5 || k == 11) ? 1 : 0);
    end
    chk("held_result", 32'($signed(result)), 3);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);

    // Randomized operands, biased toward extreme values
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) begin
        pick = int'($urandom_range(0, 3));
        xv[i] = (pick == 0) ? 8'h80 : (pick == 1) ? 8'h7f : 8'($urandom);
        pick = int'($urandom_range(0, 3));
        wv[i] = (pick == 0) ? 8'h80 : (pick == 1) ? 8'h7f : 8'($urandom);
      end
      b = 8'($urandom);
      do_op("rand", xv, wv, b, ref_model(xv, wv, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
